mandel_result_arbiter: RTL and testbench

Round-robin scheduler that shares the 15-input, 12-bit result multiplexer between the Mandelbrot iteration cores. Each core raises a request when its pixel colour is ready. The arbiter picks one core at a time, drives the multiplexer select, and captures the selected 12-bit value. It acknowledges the winning core and then presents the value and source index to the frame-buffer writer over a valid/ready handshake.

---
 rtl/mandel_result_arbiter_if.sv | 30 +++
 rtl/mandel_result_arbiter.sv | 117 +++++++++++
 tb/tb_mandel_result_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_result_arbiter_if.sv
// rtl/mandel_result_arbiter_if.sv - core/mux/frame-buffer bus of the result arbiter
// Signals:
//   req/ack          per-core request and one-cycle acknowledge
//   select/mux_q     registered mux select and the mux output returned
//   out_valid/out_ready/out_data/out_src  handshake towards the frame-buffer writer
// master: the arbiter side. slave: the cores, mux and writer side.
interface mandel_result_arbiter_if #(
    parameter int N_REQ        = 15,
    parameter int DATA_WIDTH   = 12,
    parameter int SELECT_WIDTH = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        ack;
    logic [SELECT_WIDTH-1:0] select;
    logic [DATA_WIDTH-1:0]   mux_q;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [SELECT_WIDTH-1:0] out_src;

    modport master (
        input  req, mux_q, out_ready,
        output ack, select, out_valid, out_data, out_src
    );

    modport slave (
        output req, mux_q, out_ready,
        input  ack, select, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mandel_result_arbiter.sv
// rtl/mandel_result_arbiter.sv - round-robin scheduler for the shared result multiplexer
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous, active-high
//   enable  gates new grants only; a transfer in flight always completes
//   busy    high whenever the FSM is not in IDLE
//   bus     master side of mandel_result_arbiter_if (req/ack, select/mux_q, out_* handshake)
module mandel_result_arbiter #(
    parameter int N_REQ        = 15,
    parameter int DATA_WIDTH   = 12,
    parameter int SELECT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    busy,
    mandel_result_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SELECT_WIDTH-1:0] ptr;
    logic [SELECT_WIDTH-1:0] select_q;
    logic [SELECT_WIDTH-1:0] winner;
    logic                    found;
    logic                    grant;
    logic [N_REQ-1:0]        ack_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [SELECT_WIDTH-1:0] out_src_q;
    logic                    out_valid_q;
    int                      idx;

    // Circular search starting at ptr+1. Scanning from the farthest candidate
    // towards the nearest lets the nearest requester overwrite the others.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (bus.req[SELECT_WIDTH'(idx)]) begin
                winner = SELECT_WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && found) begin
                    grant      = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = OUTPUT;
            OUTPUT: begin
                if (out_valid_q && bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            select_q    <= '0;
            ptr         <= SELECT_WIDTH'(N_REQ - 1);
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ack_q <= '0;
            if (grant) begin
                select_q <= winner;
                ptr      <= winner;
            end
            // The mux has had the whole CAPTURE cycle to settle on select_q.
            if (state == CAPTURE) begin
                out_data_q  <= bus.mux_q;
                out_src_q   <= select_q;
                out_valid_q <= 1'b1;
                ack_q       <= N_REQ'(1) << select_q;
            end
            if (state == OUTPUT && out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ack       = ack_q;
    assign bus.select    = select_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_mandel_result_arbiter.sv
// tb/tb_mandel_result_arbiter.sv - self-checking bench for mandel_result_arbiter
module tb_mandel_result_arbiter;
    localparam int N  = 15;
    localparam int DW = 12;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic busy;

    mandel_result_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) bus ();

    mandel_result_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Result mux model: one pixel colour per core.
    logic [DW-1:0] dmem [0:15];
    assign bus.mux_q = dmem[bus.select];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = N - 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the winner is the requester at the smallest circular
    // distance after the last served core.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N + 1;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - p - 1 + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic int ack_index(input logic [N-1:0] a);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (a[i]) r = i;
        return r;
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < 16; i++) dmem[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
        repeat (2) tick();
        n_checks++;
        if ({bus.select, bus.ack, bus.out_valid, bus.out_data, bus.out_src, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got sel=%0d ack=%h v=%b d=%h src=%0d busy=%b, expected all 0",
                     bus.select, bus.ack, bus.out_valid, bus.out_data, bus.out_src, busy);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({bus.select, bus.ack, bus.out_valid, bus.out_data, bus.out_src, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_released: got sel=%0d ack=%h v=%b busy=%b, expected all 0",
                     bus.select, bus.ack, bus.out_valid, busy);
        end
        exp_ptr = N - 1;
    endtask

    task automatic test_single();
        dmem[5] = 12'hABC;
        enable = 1'b1;
        bus.out_ready = 1'b1;
        bus.req = 15'h0020;
        tick();
        n_checks++;
        if ({bus.select, busy, bus.out_valid} !== {4'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_grant: got sel=%0d busy=%b v=%b, expected sel=5 busy=1 v=0",
                     bus.select, busy, bus.out_valid);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 12'hABC || bus.out_src !== 4'd5) begin
            n_fail++;
            $display("FAIL single_output: got v=%b d=%h src=%0d, expected v=1 d=abc src=5",
                     bus.out_valid, bus.out_data, bus.out_src);
        end
        n_checks++;
        if (bus.ack !== 15'h0020) begin
            n_fail++;
            $display("FAIL single_ack: got %h expected 0020", bus.ack);
        end
        bus.req = '0;
        tick();
        n_checks++;
        if ({bus.ack, bus.out_valid, busy} !== '0) begin
            n_fail++;
            $display("FAIL single_done: got ack=%h v=%b busy=%b, expected 0 0 0",
                     bus.ack, bus.out_valid, busy);
        end
        exp_ptr = 5;
    endtask

    task automatic test_all_requesting();
        int grants[$];
        int last_cyc;
        int cyc;
        int idx;
        int exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ptr = N - 1;
        randomize_data();
        enable = 1'b1;
        bus.out_ready = 1'b1;
        bus.req = '1;
        last_cyc = -1;
        cyc = 0;
        while (grants.size() < N && cyc < 200) begin
            tick();
            cyc++;
            if (bus.ack != '0) begin
                idx = ack_index(bus.ack);
                exp = rr_pick(bus.req, exp_ptr);
                n_checks++;
                if (idx != exp || bus.ack !== (15'(1) << exp)) begin
                    n_fail++;
                    $display("FAIL all_order: got ack=%h expected core %0d", bus.ack, exp);
                end
                n_checks++;
                if (bus.out_data !== dmem[exp] || bus.out_src !== SW'(exp)) begin
                    n_fail++;
                    $display("FAIL all_data: got d=%h src=%0d expected d=%h src=%0d",
                             bus.out_data, bus.out_src, dmem[exp], exp);
                end
                if (last_cyc >= 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 3) begin
                        n_fail++;
                        $display("FAIL all_rate: got %0d cycles between grants expected 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                grants.push_back(idx);
                if (idx >= 0) bus.req[idx] = 1'b0;
                exp_ptr = exp;
            end
        end
        n_checks++;
        if (grants.size() != N || grants[0] != 0 || grants[N-1] != N - 1) begin
            n_fail++;
            $display("FAIL all_count: got %0d grants (first %0d) expected 15 from 0 to 14",
                     grants.size(), grants.size() > 0 ? grants[0] : -1);
        end
        repeat (2) tick();
    endtask

    task automatic test_fairness_wrap();
        int got[$];
        int cyc;
        int exp;
        int idx;
        bus.req = 15'h4001;
        cyc = 0;
        while (got.size() < 2 && cyc < 50) begin
            tick();
            cyc++;
            if (bus.ack != '0) begin
                idx = ack_index(bus.ack);
                exp = rr_pick(bus.req, exp_ptr);
                n_checks++;
                if (idx != exp) begin
                    n_fail++;
                    $display("FAIL wrap_order: got core %0d expected core %0d", idx, exp);
                end
                got.push_back(idx);
                if (idx >= 0) bus.req[idx] = 1'b0;
                exp_ptr = exp;
            end
        end
        n_checks++;
        if (got.size() != 2 || got[0] != 0 || got[1] != 14) begin
            n_fail++;
            $display("FAIL wrap_sequence: got %0d grants first=%0d, expected 0 then 14",
                     got.size(), got.size() > 0 ? got[0] : -1);
        end
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] sel0;
        logic [DW-1:0] d0;
        logic [SW-1:0] s0;
        int acks;
        randomize_data();
        bus.out_ready = 1'b0;
        bus.req = 15'h0080;
        tick();
        sel0 = bus.select;
        tick();
        acks = (bus.ack != '0) ? 1 : 0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== dmem[7] || bus.out_src !== 4'd7) begin
            n_fail++;
            $display("FAIL bp_capture: got v=%b d=%h src=%0d expected v=1 d=%h src=7",
                     bus.out_valid, bus.out_data, bus.out_src, dmem[7]);
        end
        d0 = bus.out_data;
        s0 = bus.out_src;
        // Core 7 is served; core 2 requests while the writer stalls and must be ignored.
        bus.req = 15'h0004;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.ack != '0) acks++;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || bus.out_src !== s0 || bus.select !== sel0) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d got v=%b d=%h src=%0d sel=%0d expected v=1 d=%h src=%0d sel=%0d",
                         c, bus.out_valid, bus.out_data, bus.out_src, bus.select, d0, s0, sel0);
            end
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL bp_ack_pulses: got %0d expected 1", acks);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.req = '0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b expected 0", bus.out_valid);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_single_transfer: got busy=%b v=%b expected 0 0", busy, bus.out_valid);
        end
        exp_ptr = 7;
    endtask

    task automatic test_enable_and_reset();
        int bad;
        enable = 1'b0;
        bus.out_ready = 1'b1;
        bus.req = 15'h0008;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || bus.ack !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL enable_low: got %0d cycles with busy/ack set expected 0", bad);
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if (bus.select !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_grant: got sel=%0d busy=%b expected sel=3 busy=1", bus.select, busy);
        end
        tick();
        n_checks++;
        if (bus.ack !== 15'h0008) begin
            n_fail++;
            $display("FAIL enable_ack: got %h expected 0008", bus.ack);
        end
        bus.req = '0;
        repeat (2) tick();
        exp_ptr = 3;

        bus.req = 15'h0011;
        tick();
        n_checks++;
        if (bus.select !== SW'(rr_pick(15'h0011, exp_ptr))) begin
            n_fail++;
            $display("FAIL rst_pre_grant: got sel=%0d expected %0d", bus.select, rr_pick(15'h0011, exp_ptr));
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.ack, bus.out_valid, busy, bus.select} !== '0) begin
            n_fail++;
            $display("FAIL rst_in_capture: got ack=%h v=%b busy=%b sel=%0d expected all 0",
                     bus.ack, bus.out_valid, busy, bus.select);
        end
        tick();
        reset = 1'b0;
        exp_ptr = N - 1;
        tick();
        n_checks++;
        if (bus.select !== SW'(rr_pick(15'h0011, exp_ptr)) || bus.select !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_priority: got sel=%0d expected 0", bus.select);
        end
        tick();
        n_checks++;
        if (bus.ack !== 15'h0001) begin
            n_fail++;
            $display("FAIL rst_ack: got %h expected 0001", bus.ack);
        end
        bus.req = '0;
        repeat (2) tick();
        exp_ptr = 0;
    endtask

    task automatic test_random();
        logic [N-1:0] set;
        logic [N-1:0] s;
        logic pv;
        logic pr;
        logic [DW-1:0] pd;
        logic [SW-1:0] ps;
        int order[$];
        int got[$];
        int p;
        int w;
        int idx;
        int cyc;
        int bad;
        for (int r = 0; r < 8; r++) begin
            randomize_data();
            set = N'($urandom_range(1, (1 << N) - 1));
            order.delete();
            got.delete();
            s = set;
            p = exp_ptr;
            while (s != '0) begin
                w = rr_pick(s, p);
                order.push_back(w);
                s[w] = 1'b0;
                p = w;
            end
            bus.req = set;
            cyc = 0;
            while (got.size() < order.size() && cyc < 400) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                pv = bus.out_valid;
                pr = bus.out_ready;
                pd = bus.out_data;
                ps = bus.out_src;
                tick();
                cyc++;
                if (pv && !pr) begin
                    n_checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_src !== ps) begin
                        n_fail++;
                        $display("FAIL rnd_stall_hold: got v=%b d=%h src=%0d expected v=1 d=%h src=%0d",
                                 bus.out_valid, bus.out_data, bus.out_src, pd, ps);
                    end
                end
                if (pv && pr) begin
                    n_checks++;
                    if (bus.out_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd_handshake: got v=%b expected 0", bus.out_valid);
                    end
                end
                if (bus.ack != '0) begin
                    idx = ack_index(bus.ack);
                    n_checks++;
                    if (idx < 0 || bus.ack !== (15'(1) << idx) || bus.out_src !== SW'(idx) ||
                        bus.out_data !== dmem[idx] || bus.out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rnd_result: got ack=%h src=%0d d=%h v=%b", bus.ack,
                                 bus.out_src, bus.out_data, bus.out_valid);
                    end
                    got.push_back(idx);
                    if (idx >= 0) bus.req[idx] = 1'b0;
                end
            end
            bus.out_ready = 1'b1;
            repeat (2) tick();
            bad = (got.size() != order.size()) ? 1 : 0;
            for (int k = 0; k < got.size() && k < order.size(); k++) if (got[k] != order[k]) bad = 1;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rnd_order: round %0d req=%h got %0d grants expected %0d in round-robin order",
                         r, set, got.size(), order.size());
            end
            if (order.size() > 0) exp_ptr = order[order.size() - 1];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_fairness_wrap();
        test_backpressure();
        test_enable_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
